trigger_cmd_decoder: RTL
========================

# trigger_cmd_decoder

Parametrised decoder for the serial trigger-command lane arriving at the front-end board. Every clock it samples a strobe bit and a command code. It converts accepted commands into one-cycle L1A/DELTA/ALIGN/PL1A pulses, tags each L1A with an event number, and enforces a programmable hold-off between commands. Rejected strobes are flagged. It sits between the trigger-link deserialiser and the readout/timing control logic.

## Interface
- `CODE_W`, 3: command code width; must be ≥ 3.
- `HOLDOFF`, 3: cycles after reset or after an accepted strobe during which strobes are rejected; 0 disables hold-off.
- `EVT_W`, 16: event-number width.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: decode enable; when low, strobes are ignored with no pulses and no errors.
- `in_stb` in 1: command strobe (lane MSB).
- `in_code` in CODE_W: command code, qualified by `in_stb`.
- `l1a`, `delta`, `align`, `pl1a` out 1: one-cycle command pulses.
- `evt_num` out EVT_W: event number, valid while `l1a` = 1.
- `err_unknown` out 1: pulse; the accepted strobe carried an unmapped code.
- `err_busy` out 1: pulse; a strobe arrived during hold-off.
- `err_count` out 16: saturating count of rejected or unknown strobes (see Configuration).

## Operation
- Code map, zero-extended to CODE_W:
  - 0 → L1A
  - 1 → DELTA
  - 2 → ALIGN
  - 6 → PL1A
  - Every other code is unknown.
- FSM states are HOLD and READY. Reset enters HOLD with `hold_cnt` = 0.
- In HOLD, `hold_cnt` increments every cycle. On the edge where `hold_cnt` = HOLDOFF−1, the FSM moves to READY. HOLD therefore lasts exactly HOLDOFF cycles. If HOLDOFF = 0, the FSM is permanently READY.
- An accepted strobe requires `en`=1, `in_stb`=1 and state READY.
  - It drives the mapped pulse, or `err_unknown` for an unknown code.
  - It reloads `hold_cnt` = 0 and enters HOLD. Unknown codes also start hold-off.
- A strobe with `en`=1 while in HOLD produces an `err_busy` pulse. It does not restart hold-off and no command pulse is generated.
- `en` low does not freeze the hold-off counter.
- Event number:
  - `evt_num` presents the internal counter value alongside each `l1a` pulse.
  - The counter increments after each L1A and wraps from 2^EVT_W−1 to 0.
  - ALIGN clears the counter, so the first L1A after reset or ALIGN carries 0.
  - PL1A and DELTA do not change the counter.
- Pulses are mutually exclusive by construction, because only one code is decoded per cycle.
- Reset values:
  - All pulses = 0.
  - `evt_num` = 0, event counter = 0.
  - `err_count` = 0.
  - State = HOLD, `hold_cnt` = 0.
- Reset asserted mid-operation immediately clears all outputs, including any pulse in flight.

## Timing
- Latency is 1 cycle. A strobe sampled at edge k gives a pulse high from edge k until edge k+1.
- Minimum accepted-strobe spacing is HOLDOFF+1 cycles. Back-to-back strobes with HOLDOFF=3 are accepted at k, k+4, k+8, …; the strobes at k+1..k+3 raise `err_busy`.
- After reset release, the first strobe can be accepted at the (HOLDOFF+1)th rising edge.
- `evt_num` updates on the same edge as `l1a` and holds its value between L1As.
- `err_count` updates on the same edge as the corresponding error pulse.

## Configuration
- `TRIG_DEC_ERRCNT_EN` defined:
  - `err_count` increments on each `err_unknown` or `err_busy` pulse.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: `err_count` is tied to 0 and the counter logic is absent. The error pulses are unaffected.

## Structure
- Shared package `trigger_pkg` holds:
  - the command code constants CMD_L1A, CMD_DELTA, CMD_ALIGN, CMD_PL1A;
  - the FSM state enum (ST_HOLD, ST_READY).
- One sub-module, `trig_holdoff_timer`, contains the HOLD/READY FSM and `hold_cnt`.
  - Width of `hold_cnt` is $clog2(HOLDOFF+1).
  - Interface: `clk`, `rst_n`, `restart` in, `ready` out.
- Decode, event counter and error counter live in the top module.

## Test plan
- Reset release with HOLDOFF=3, L1A strobe held every cycle → `l1a` at cycles 4, 8, 12; `err_busy` on all other cycles; `evt_num` = 0, 1, 2.
- L1A ×5, ALIGN, L1A (spaced 4 cycles) → `evt_num` 0..4, `align` pulse, then next `evt_num` = 0.
- EVT_W=4 with 17 spaced L1As → `evt_num` sequence 0..15, 0.
- Codes 3, 4, 5, 7 each strobed in READY → `err_unknown` pulse each time, no command pulse, hold-off restarted; with `TRIG_DEC_ERRCNT_EN`, `err_count` = 4.
- `en` = 0 with strobes every cycle → no pulses, no errors; raise `en` → first strobe accepted immediately if hold-off has elapsed.
- `rst_n` asserted during an `l1a` pulse → all outputs 0 asynchronously; after release, hold-off of 3 cycles applies and `evt_num` restarts at 0.

Source files
------------

// File: rtl/trigger_pkg.sv
// -----------------------------------------------------------------------------
// trigger_pkg
//   Shared definitions for the trigger-command decoder slice:
//     - command code constants (3-bit, zero-extended by users to CODE_W)
//     - hold-off FSM state encoding
//   No ports; imported by trig_holdoff_timer and trigger_cmd_decoder.
// -----------------------------------------------------------------------------
package trigger_pkg;

    // Command codes as they appear on the trigger lane.
    localparam logic [2:0] CMD_L1A   = 3'd0;
    localparam logic [2:0] CMD_DELTA = 3'd1;
    localparam logic [2:0] CMD_ALIGN = 3'd2;
    localparam logic [2:0] CMD_PL1A  = 3'd6;

    // Hold-off FSM: HOLD rejects strobes, READY accepts the next one.
    typedef enum logic [0:0] {
        ST_HOLD  = 1'b0,
        ST_READY = 1'b1
    } holdoff_state_e;

endpackage : trigger_pkg

// File: rtl/trig_holdoff_timer.sv
// -----------------------------------------------------------------------------
// trig_holdoff_timer
//   HOLD/READY FSM enforcing a minimum spacing between accepted trigger
//   commands. After reset, or after `restart`, the FSM sits in HOLD for exactly
//   HOLDOFF cycles and then reports `ready`. HOLDOFF = 0 means always ready.
//
// Parameters
//   HOLDOFF  hold-off length in cycles (0 disables hold-off)
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset (enters HOLD, hold_cnt = 0)
//   restart  an accepted strobe this cycle: reload hold_cnt and enter HOLD
//   ready    FSM is in READY, the current strobe may be accepted
// -----------------------------------------------------------------------------
module trig_holdoff_timer
    import trigger_pkg::*;
#(
    parameter int HOLDOFF = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic ready
);

    generate
        if (HOLDOFF == 0) begin : g_no_holdoff
            // Permanently READY; the clock, reset and restart have no effect.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, restart};
            assign ready = 1'b1;
        end else begin : g_fsm
            localparam int CNT_W = $clog2(HOLDOFF + 1);
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLDOFF - 1);

            holdoff_state_e   state, state_nxt;
            logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge value of every other flop.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                end else begin
                    state    <= state_nxt;
                    hold_cnt <= hold_cnt_nxt;
                end
            end

            // NOTE: every output of this block is assigned a default first,
            // so no path leaves a variable unassigned and no latch is inferred.
            always_comb begin
                state_nxt    = state;
                hold_cnt_nxt = hold_cnt;
                if (restart) begin
                    state_nxt    = ST_HOLD;
                    hold_cnt_nxt = '0;
                end else if (state == ST_HOLD) begin
                    // Counter reaches HOLDOFF on the exit edge; the width
                    // $clog2(HOLDOFF+1) holds that value without wrapping.
                    hold_cnt_nxt = hold_cnt + 1'b1;
                    if (hold_cnt == LAST_CNT) begin
                        state_nxt = ST_READY;
                    end
                end
            end

            assign ready = (state == ST_READY);
        end
    endgenerate

endmodule : trig_holdoff_timer

// File: rtl/trigger_cmd_decoder.sv
// -----------------------------------------------------------------------------
// trigger_cmd_decoder
//   Decodes the serial trigger-command lane into one-cycle L1A / DELTA /
//   ALIGN / PL1A pulses, tags each L1A with an event number and enforces a
//   programmable hold-off between accepted commands. Strobes arriving during
//   hold-off raise err_busy; accepted strobes with an unmapped code raise
//   err_unknown (and still start hold-off). All outputs are registered, so a
//   strobe sampled on edge k produces its pulse from edge k to edge k+1.
//
// Optional feature (macro TRIG_DEC_ERRCNT_EN)
//   defined   : err_count counts err_unknown/err_busy pulses, saturating at
//               16'hFFFF, cleared only by reset.
//   undefined : err_count is tied to zero.
//
// Parameters
//   CODE_W   command code width (must be >= 3)
//   HOLDOFF  hold-off length in cycles, 0 disables
//   EVT_W    event-number width
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   en                   decode enable; low ignores strobes entirely
//   in_stb, in_code      command strobe and code
//   l1a, delta, align,
//   pl1a                 one-cycle command pulses
//   evt_num              event number, valid while l1a = 1
//   err_unknown          accepted strobe carried an unmapped code
//   err_busy             strobe arrived during hold-off
//   err_count            saturating error counter (see macro above)
// -----------------------------------------------------------------------------
module trigger_cmd_decoder
    import trigger_pkg::*;
#(
    parameter int CODE_W  = 3,
    parameter int HOLDOFF = 3,
    parameter int EVT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_stb,
    input  logic [CODE_W-1:0] in_code,
    output logic              l1a,
    output logic              delta,
    output logic              align,
    output logic              pl1a,
    output logic [EVT_W-1:0]  evt_num,
    output logic              err_unknown,
    output logic              err_busy,
    output logic [15:0]       err_count
);

    logic ready;
    logic accept;
    logic hit_l1a, hit_delta, hit_align, hit_pl1a, hit_unknown, hit_busy;

    logic [EVT_W-1:0] evt_cnt;

    trig_holdoff_timer #(
        .HOLDOFF (HOLDOFF)
    ) u_holdoff (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (accept),
        .ready   (ready)
    );

    // Only one code is looked at per cycle, so the hit_* terms are mutually
    // exclusive and so are the registered pulses.
    always_comb begin
        accept      = en && in_stb && ready;
        hit_busy    = en && in_stb && !ready;
        hit_l1a     = accept && (in_code == CODE_W'(CMD_L1A));
        hit_delta   = accept && (in_code == CODE_W'(CMD_DELTA));
        hit_align   = accept && (in_code == CODE_W'(CMD_ALIGN));
        hit_pl1a    = accept && (in_code == CODE_W'(CMD_PL1A));
        hit_unknown = accept && !(hit_l1a || hit_delta || hit_align || hit_pl1a);
    end

    // Pulse outputs: high for exactly the cycle after the strobe is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1a         <= 1'b0;
            delta       <= 1'b0;
            align       <= 1'b0;
            pl1a        <= 1'b0;
            err_unknown <= 1'b0;
            err_busy    <= 1'b0;
        end else begin
            l1a         <= hit_l1a;
            delta       <= hit_delta;
            align       <= hit_align;
            pl1a        <= hit_pl1a;
            err_unknown <= hit_unknown;
            err_busy    <= hit_busy;
        end
    end

    // Event counter: evt_num captures the count alongside each L1A and holds
    // between L1As; the internal count then advances (wrapping naturally).
    // ALIGN clears only the internal count so the next L1A carries 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
            evt_num <= '0;
        end else if (hit_l1a) begin
            evt_num <= evt_cnt;
            evt_cnt <= evt_cnt + 1'b1;
        end else if (hit_align) begin
            evt_cnt <= '0;
        end
    end

`ifdef TRIG_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if ((hit_unknown || hit_busy) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule : trigger_cmd_decoder
